// File: rtl/wb_regfile.sv
// Write-back register file: write-back mux, commit gated by the write-back stage,
// two combinational read ports with same-cycle bypass, and a pending-write scoreboard.
module wb_regfile #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned STAGE_WIDTH = 3,
    parameter int unsigned WB_STAGE    = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [STAGE_WIDTH-1:0] stage,
    input  logic                   regWrite,
    input  logic                   memToReg,
    input  logic                   regDest,
    input  logic [ADDR_WIDTH-1:0]  address1,
    input  logic [ADDR_WIDTH-1:0]  address2,
    input  logic [DATA_WIDTH-1:0]  value,
    input  logic [DATA_WIDTH-1:0]  aluOut,
    input  logic [ADDR_WIDTH-1:0]  readAddrA,
    input  logic [ADDR_WIDTH-1:0]  readAddrB,
    output logic [DATA_WIDTH-1:0]  readDataA,
    output logic [DATA_WIDTH-1:0]  readDataB,
    input  logic                   reserveValid,
    input  logic [ADDR_WIDTH-1:0]  reserveAddr,
    output logic                   busyA,
    output logic                   busyB,
    output logic                   hazard,
    output logic [COUNT_WIDTH-1:0] writeCount
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [STAGE_WIDTH-1:0] WB_STAGE_V = STAGE_WIDTH'(WB_STAGE);

    logic [DATA_WIDTH-1:0]  regs_q [DEPTH];
    logic [DATA_WIDTH-1:0]  regs_d [DEPTH];
    logic [DEPTH-1:0]       pending_q;
    logic [DEPTH-1:0]       pending_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    logic [DATA_WIDTH-1:0] wb_data;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic                  commit;

    always_comb begin
        wb_data = memToReg ? value : aluOut;
        wb_addr = regDest ? address2 : address1;
        commit  = resetn && regWrite && (stage == WB_STAGE_V) && (wb_addr != '0);
    end

    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // Clear before set so a newer reservation of the same register survives the commit.
    always_comb begin
        pending_d = pending_q;
        if (commit) begin
            pending_d[wb_addr] = 1'b0;
        end
        if (reserveValid && (reserveAddr != '0)) begin
            pending_d[reserveAddr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        count_d = count_q;
        if (commit && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            regs_q    <= '{default: '0};
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        if (readAddrA == '0) begin
            readDataA = '0;
        end else if (commit && (wb_addr == readAddrA)) begin
            readDataA = wb_data;
        end else begin
            readDataA = regs_q[readAddrA];
        end

        if (readAddrB == '0) begin
            readDataB = '0;
        end else if (commit && (wb_addr == readAddrB)) begin
            readDataB = wb_data;
        end else begin
            readDataB = regs_q[readAddrB];
        end

        busyA      = pending_q[readAddrA] && !(commit && (wb_addr == readAddrA));
        busyB      = pending_q[readAddrB] && !(commit && (wb_addr == readAddrB));
        hazard     = busyA || busyB;
        writeCount = count_q;
    end

endmodule
